spi_slv: RTL and testbench
==========================

SPI_SLV -- requirements
Module: spi_slv

Interface
REQ-001 pCPOL, 0, SCK idle level.
REQ-002 pCPHA, 0, 0: sample on leading edge and shift on trailing edge; 1: shift on leading edge and sample on trailing edge.
REQ-003 pDefTx, 8'hFF, byte shifted out when the transmit holding register is empty (underrun).
REQ-004 Clk  in  1  system clock; the only clock.
REQ-005 Rst  in  1  synchronous, active-high reset.
REQ-006 nCS  in  1  SPI slave select, active low, asynchronous to Clk.
REQ-007 SCK  in  1  SPI clock, asynchronous, frequency no more than Clk/4.
REQ-008 MOSI  in  1  serial data in, MSB first.
REQ-009 MISO  out  1  serial data out, MSB first.
REQ-010 MISO_OE  out  1  MISO output enable; high only while synchronized nCS is low.
REQ-011 TD  in  8  transmit byte.
REQ-012 TD_WE  in  1  one-Clk strobe that writes TD into the transmit holding register (THR).
REQ-013 TRdy  out  1  THR empty.
REQ-014 RD  out  8  receive holding register (RHR).
REQ-015 RD_RE  in  1  one-Clk strobe that acknowledges RHR.
REQ-016 RRdy  out  1  RHR holds unread data.

Function
REQ-020 nCS, SCK and MOSI shall each pass a 2-FF synchronizer; SCK edges shall be detected by comparing the 2nd and 3rd stages.
REQ-021 The FSM shall have three states: Idle, Load, Shift.
REQ-022 Idle -> Load on the nCS falling edge; Load -> Shift after exactly 1 Clk; Shift -> Idle on the nCS rising edge.
REQ-023 Load shall copy THR into the shift register (SR), or pDefTx if TRdy=1, set TRdy=1, and clear the bit counter.
REQ-024 Sample edge: SR <= {SR[6:0], MOSI_s}; bit counter increments.
REQ-025 Shift edge: MISO <= next SR MSB.
REQ-026 pCPHA=0: MISO shall present SR[7] from Load onward.
REQ-027 Byte complete when the bit counter wraps from 7 to 0, then in the same Clk:
- RD <= SR;
- RRdy <= 1;
- SR reloads from THR or pDefTx per REQ-023, so back-to-back bytes continue without deselect.
REQ-028 An nCS rise mid-byte shall discard the partial byte; RHR and RRdy shall be unchanged; the counter shall clear.
REQ-029 TD_WE shall set TRdy=0 and overwrite THR even if TRdy=0.
REQ-030 If TD_WE coincides with a Load or reload, the new TD shall be loaded into SR and TRdy shall end at 1.
REQ-031 RD_RE shall clear RRdy.
REQ-032 If RD_RE coincides with byte completion, RRdy shall end at 1 with the new byte.
REQ-033 SCK edges while in Idle or Load shall be ignored.
REQ-034 Latency from the pin edge to an internal action shall be 3 Clk.

Reset
REQ-040 Rst shall force all of the following:
- state = Idle;
- SR = 0 and bit counter = 0;
- THR = pDefTx and TRdy = 1;
- RD = 0 and RRdy = 0;
- MISO = 0 and MISO_OE = 0;
- synchronizers set to nCS=1 and SCK=pCPOL;
- OVR = 0.
REQ-041 Rst mid-transfer shall abort immediately; the slave shall wait for a fresh nCS falling edge.

Configuration
REQ-050 Macro SPI_SLV_OVR_EN shall control overrun handling.
REQ-051 Defined: adds output OVR (1 bit, sticky).
- A byte completing with RRdy=1 shall be dropped and RD kept.
- OVR shall be set.
- RD_RE shall clear OVR.
REQ-052 Undefined: no OVR port; a completing byte shall always overwrite RD.

Structure
REQ-060 A shared package spi_pkg shall hold:
- the state enumeration (Idle, Load, Shift);
- the bit-counter width (3);
- the default pDefTx constant.
REQ-061 One sub-module, spi_sync, shall implement a 2-FF synchronizer with a parameterized reset value, instantiated three times.

Verification
REQ-070 Mode 0, THR=8'hA5, master sends 8'h3C at Clk/8 -> MISO bits 1,0,1,0,0,1,0,1; RD=8'h3C; RRdy=1; TRdy=1.
REQ-071 Mode 3, no TD_WE, master sends 8'h81 -> MISO shifts out 8'hFF; RD=8'h81.
REQ-072 Two back-to-back bytes 8'h12, 8'h34 under one nCS, with RD_RE after the first -> RD=8'h12, then 8'h34; RRdy pulses twice.
REQ-073 nCS rises after 5 SCK edges -> RRdy stays 0; the next full byte 8'h55 yields RD=8'h55.
REQ-074 With SPI_SLV_OVR_EN, bytes 8'hAA then 8'hBB without RD_RE -> RD=8'hAA, OVR=1; RD_RE clears both flags. Without the macro -> RD=8'hBB.
REQ-075 Rst asserted mid-byte -> all outputs at reset values next Clk; MISO_OE=0 until a new nCS falling edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM states, bit-counter
// width, data width and the default underrun byte.
package spi_pkg;

  localparam int          DATA_W = 8;
  localparam int          CNT_W  = 3;
  localparam logic [7:0]  DEF_TX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_slv_if.sv
// Host-side holding-register bus of the SPI slave.
// master = host (writes TD, acks RD), slave = spi_slv.
interface spi_slv_if;
  import spi_pkg::*;

  logic [DATA_W-1:0] TD;
  logic              TD_WE;
  logic              TRdy;
  logic [DATA_W-1:0] RD;
  logic              RD_RE;
  logic              RRdy;

  modport master (output TD, TD_WE, RD_RE, input  TRdy, RD, RRdy);
  modport slave  (input  TD, TD_WE, RD_RE, output TRdy, RD, RRdy);

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input, with a configurable
// value forced during reset.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1, r_s2;

  // Two-stage resynchronization into the Clk domain
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/spi_slv.sv
// SPI slave, single Clk domain. nCS/SCK/MOSI are oversampled through
// synchronizers; SCK edges are found between sync stage 2 and a third flop,
// giving 3 Clk from pin edge to action. Byte-wide holding registers (THR/RHR)
// face the host via spi_slv_if.
// Optional feature: define SPI_SLV_OVR_EN to add the sticky o_OVR output and
// drop bytes that complete while RHR is still unread.
module spi_slv
  import spi_pkg::*;
#(
  parameter bit                pCPOL  = 1'b0,
  parameter bit                pCPHA  = 1'b0,
  parameter logic [DATA_W-1:0] pDefTx = DEF_TX
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_nCS,
  input  logic       i_SCK,
  input  logic       i_MOSI,
  output logic       o_MISO,
  output logic       o_MISO_OE,
`ifdef SPI_SLV_OVR_EN
  output logic       o_OVR,
`endif
  spi_slv_if.slave   bus
);

  logic w_ncs_s, w_sck_s, w_mosi_s;
  logic r_ncs_d, r_sck_d;
  logic [1:0] r_vld;
  logic r_arm;

  state_t r_state, w_next;
  logic w_load, w_in_shift;

  logic w_ncs_fall, w_ncs_rise, w_sck_edge, w_lead, w_trail;
  logic w_samp, w_shift, w_done, w_reload, w_drop, w_wr_rd;

  logic [DATA_W-1:0] r_sr, r_thr, r_rd, w_load_byte, w_sr_next;
  logic [CNT_W-1:0]  r_cnt;
  logic r_trdy, r_rrdy, r_miso;

  spi_sync #(.RST_VAL(1'b1))  u_sync_ncs  (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_d(i_nCS),  .o_q(w_ncs_s));
  spi_sync #(.RST_VAL(pCPOL)) u_sync_sck  (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_d(i_SCK),  .o_q(w_sck_s));
  spi_sync #(.RST_VAL(1'b0))  u_sync_mosi (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_d(i_MOSI), .o_q(w_mosi_s));

  // Third stage for edge detection; r_arm blocks the fake nCS fall that a
  // reset would otherwise create while the pin is still held low.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_ncs_d <= 1'b1;
      r_sck_d <= pCPOL;
      r_vld   <= '0;
      r_arm   <= 1'b0;
    end else begin
      r_ncs_d <= w_ncs_s;
      r_sck_d <= w_sck_s;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && w_ncs_s) r_arm <= 1'b1;
    end
  end

  assign w_ncs_fall = r_arm & r_ncs_d & ~w_ncs_s;
  assign w_ncs_rise = w_ncs_s & ~r_ncs_d;
  assign w_sck_edge = w_sck_s ^ r_sck_d;
  assign w_lead     = w_sck_edge & (r_sck_d == pCPOL);
  assign w_trail    = w_sck_edge & (r_sck_d != pCPOL);

  // FSM state register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state and phase qualifiers
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_in_shift = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_ncs_fall) w_next = ST_LOAD;
      ST_LOAD: begin
        w_load = 1'b1;
        w_next = w_ncs_rise ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_ncs_rise) w_next = ST_IDLE;
        else            w_in_shift = 1'b1;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_samp      = w_in_shift & (pCPHA ? w_trail : w_lead);
  assign w_shift     = w_in_shift & (pCPHA ? w_lead  : w_trail);
  assign w_done      = w_samp & (r_cnt == '1);
  assign w_reload    = w_load | w_done;
  assign w_sr_next   = {r_sr[DATA_W-2:0], w_mosi_s};
  // A same-cycle TD_WE bypasses THR so the fresh byte is what gets sent
  assign w_load_byte = bus.TD_WE ? bus.TD : (r_trdy ? pDefTx : r_thr);

`ifdef SPI_SLV_OVR_EN
  assign w_drop = w_done & r_rrdy & ~bus.RD_RE;
`else
  assign w_drop = 1'b0;
`endif
  assign w_wr_rd = w_done & ~w_drop;

  // Shift register, bit counter and MISO
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_miso <= 1'b0;
    end else begin
      if (w_reload)    r_sr <= w_load_byte;
      else if (w_samp) r_sr <= w_sr_next;

      if (w_load || (r_state == ST_SHIFT && w_ncs_rise)) r_cnt <= '0;
      else if (w_samp)                                   r_cnt <= r_cnt + CNT_W'(1);

      if (w_load)       r_miso <= w_load_byte[DATA_W-1];
      else if (w_shift) r_miso <= r_sr[DATA_W-1];
    end
  end

  // Host holding registers and their ready flags
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_thr  <= pDefTx;
      r_trdy <= 1'b1;
      r_rd   <= '0;
      r_rrdy <= 1'b0;
    end else begin
      if (bus.TD_WE) r_thr <= bus.TD;

      if (w_reload)       r_trdy <= 1'b1;
      else if (bus.TD_WE) r_trdy <= 1'b0;

      if (w_wr_rd) begin
        r_rd   <= w_sr_next;
        r_rrdy <= 1'b1;
      end else if (bus.RD_RE) begin
        r_rrdy <= 1'b0;
      end
    end
  end

`ifdef SPI_SLV_OVR_EN
  logic r_ovr;

  // Sticky overrun flag, cleared by the host read ack
  always_ff @(posedge i_Clk) begin
    if (i_Rst)            r_ovr <= 1'b0;
    else if (w_drop)      r_ovr <= 1'b1;
    else if (bus.RD_RE)   r_ovr <= 1'b0;
  end

  assign o_OVR = r_ovr;
`endif

  assign o_MISO    = r_miso;
  assign o_MISO_OE = ~w_ncs_s & (r_state != ST_IDLE);
  assign bus.TRdy  = r_trdy;
  assign bus.RD    = r_rd;
  assign bus.RRdy  = r_rrdy;

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: u0 runs mode 0, u1 runs mode 3.
// Build with SPI_SLV_OVR_EN defined to exercise the overrun variant.
module tb_spi_slv;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ncs, sck, miso, oe;
  logic       mosi;
  int         npass = 0;
  int         ntot  = 0;
  logic [7:0] rx;
`ifdef SPI_SLV_OVR_EN
  logic [1:0] ovr;
`endif

  always #5 clk = ~clk;

  spi_slv_if b0 ();
  spi_slv_if b1 ();

  spi_slv #(.pCPOL(1'b0), .pCPHA(1'b0)) u0 (
`ifdef SPI_SLV_OVR_EN
    .o_OVR(ovr[0]),
`endif
    .i_Clk(clk), .i_Rst(rst), .i_nCS(ncs[0]), .i_SCK(sck[0]), .i_MOSI(mosi),
    .o_MISO(miso[0]), .o_MISO_OE(oe[0]), .bus(b0));

  spi_slv #(.pCPOL(1'b1), .pCPHA(1'b1)) u1 (
`ifdef SPI_SLV_OVR_EN
    .o_OVR(ovr[1]),
`endif
    .i_Clk(clk), .i_Rst(rst), .i_nCS(ncs[1]), .i_SCK(sck[1]), .i_MOSI(mosi),
    .o_MISO(miso[1]), .o_MISO_OE(oe[1]), .bus(b1));

  function automatic logic [7:0] rd_of(input int m);
    return (m == 0) ? b0.RD : b1.RD;
  endfunction
  function automatic logic rrdy_of(input int m);
    return (m == 0) ? b0.RRdy : b1.RRdy;
  endfunction
  function automatic logic trdy_of(input int m);
    return (m == 0) ? b0.TRdy : b1.TRdy;
  endfunction

  task automatic wr_td(input int m, input logic [7:0] v);
    @(negedge clk);
    if (m == 0) begin b0.TD = v; b0.TD_WE = 1'b1; end
    else        begin b1.TD = v; b1.TD_WE = 1'b1; end
    @(negedge clk);
    b0.TD_WE = 1'b0; b1.TD_WE = 1'b0;
  endtask

  task automatic rd_ack(input int m);
    @(negedge clk);
    if (m == 0) b0.RD_RE = 1'b1; else b1.RD_RE = 1'b1;
    @(negedge clk);
    b0.RD_RE = 1'b0; b1.RD_RE = 1'b0;
  endtask

  task automatic cs_low(input int m);
    ncs[m] = 1'b0; #60;
  endtask

  task automatic cs_high(input int m);
    #40; ncs[m] = 1'b1; #60;
  endtask

  // One byte at Clk/8; master samples MISO on its sample edge.
  task automatic xfer(input int m, input logic [7:0] tx, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      if (m == 0) begin
        mosi = tx[i]; #40; sck[0] = 1'b1; r[i] = miso[0]; #40; sck[0] = 1'b0;
      end else begin
        sck[1] = 1'b0; mosi = tx[i]; #40; sck[1] = 1'b1; r[i] = miso[1]; #40;
      end
    end
  endtask

  // Mode 0: 3 rising + 2 falling SCK edges, SCK left high
  task automatic partial0();
    for (int k = 0; k < 3; k++) begin
      mosi = 1'b1; #40; sck[0] = 1'b1; #40;
      if (k < 2) sck[0] = 1'b0;
    end
  endtask

  task automatic test_reset();
    ntot++; if (b0.TRdy !== 1'b1) $display("FAIL rst_trdy0 got %b want 1", b0.TRdy); else npass++;
    ntot++; if (b0.RRdy !== 1'b0) $display("FAIL rst_rrdy0 got %b want 0", b0.RRdy); else npass++;
    ntot++; if (b0.RD !== 8'h00) $display("FAIL rst_rd0 got %h want 00", b0.RD); else npass++;
    ntot++; if (miso !== 2'b00) $display("FAIL rst_miso got %b want 00", miso); else npass++;
    ntot++; if (oe !== 2'b00) $display("FAIL rst_oe got %b want 00", oe); else npass++;
    ntot++; if (b1.TRdy !== 1'b1) $display("FAIL rst_trdy1 got %b want 1", b1.TRdy); else npass++;
`ifdef SPI_SLV_OVR_EN
    ntot++; if (ovr !== 2'b00) $display("FAIL rst_ovr got %b want 00", ovr); else npass++;
`endif
  endtask

  task automatic test_mode0();
    wr_td(0, 8'hA5);
    ntot++; if (b0.TRdy !== 1'b0) $display("FAIL m0_trdy_wr got %b want 0", b0.TRdy); else npass++;
    cs_low(0);
    ntot++; if (oe[0] !== 1'b1) $display("FAIL m0_oe got %b want 1", oe[0]); else npass++;
    ntot++; if (b0.TRdy !== 1'b1) $display("FAIL m0_trdy_load got %b want 1", b0.TRdy); else npass++;
    xfer(0, 8'h3C, rx);
    ntot++; if (rx !== 8'hA5) $display("FAIL m0_miso got %h want a5", rx); else npass++;
    ntot++; if (b0.RD !== 8'h3C) $display("FAIL m0_rd got %h want 3c", b0.RD); else npass++;
    ntot++; if (b0.RRdy !== 1'b1) $display("FAIL m0_rrdy got %b want 1", b0.RRdy); else npass++;
    cs_high(0);
    ntot++; if (oe[0] !== 1'b0) $display("FAIL m0_oe_off got %b want 0", oe[0]); else npass++;
    rd_ack(0);
    ntot++; if (b0.RRdy !== 1'b0) $display("FAIL m0_rrdy_ack got %b want 0", b0.RRdy); else npass++;
  endtask

  task automatic test_mode3();
    cs_low(1);
    xfer(1, 8'h81, rx);
    ntot++; if (rx !== 8'hFF) $display("FAIL m3_miso got %h want ff", rx); else npass++;
    ntot++; if (rd_of(1) !== 8'h81) $display("FAIL m3_rd got %h want 81", rd_of(1)); else npass++;
    ntot++; if (rrdy_of(1) !== 1'b1) $display("FAIL m3_rrdy got %b want 1", rrdy_of(1)); else npass++;
    cs_high(1);
    rd_ack(1);
    ntot++; if (rrdy_of(1) !== 1'b0) $display("FAIL m3_rrdy_ack got %b want 0", rrdy_of(1)); else npass++;
  endtask

  task automatic test_back_to_back();
    wr_td(0, 8'hC3);
    cs_low(0);
    wr_td(0, 8'hE7);
    ntot++; if (trdy_of(0) !== 1'b0) $display("FAIL b2b_trdy got %b want 0", trdy_of(0)); else npass++;
    xfer(0, 8'h12, rx);
    ntot++; if (rx !== 8'hC3) $display("FAIL b2b_miso1 got %h want c3", rx); else npass++;
    ntot++; if (rd_of(0) !== 8'h12) $display("FAIL b2b_rd1 got %h want 12", rd_of(0)); else npass++;
    ntot++; if (rrdy_of(0) !== 1'b1) $display("FAIL b2b_rrdy1 got %b want 1", rrdy_of(0)); else npass++;
    ntot++; if (trdy_of(0) !== 1'b1) $display("FAIL b2b_trdy_reload got %b want 1", trdy_of(0)); else npass++;
    rd_ack(0);
    ntot++; if (rrdy_of(0) !== 1'b0) $display("FAIL b2b_rrdy_ack got %b want 0", rrdy_of(0)); else npass++;
    xfer(0, 8'h34, rx);
    ntot++; if (rx !== 8'hE7) $display("FAIL b2b_miso2 got %h want e7", rx); else npass++;
    ntot++; if (rd_of(0) !== 8'h34) $display("FAIL b2b_rd2 got %h want 34", rd_of(0)); else npass++;
    ntot++; if (rrdy_of(0) !== 1'b1) $display("FAIL b2b_rrdy2 got %b want 1", rrdy_of(0)); else npass++;
    cs_high(0);
    rd_ack(0);
  endtask

  task automatic test_abort();
    cs_low(0);
    partial0();
    cs_high(0);
    sck[0] = 1'b0; #40;
    ntot++; if (rrdy_of(0) !== 1'b0) $display("FAIL abort_rrdy got %b want 0", rrdy_of(0)); else npass++;
    ntot++; if (rd_of(0) !== 8'h34) $display("FAIL abort_rd got %h want 34", rd_of(0)); else npass++;
    cs_low(0);
    xfer(0, 8'h55, rx);
    ntot++; if (rx !== 8'hFF) $display("FAIL abort_miso got %h want ff", rx); else npass++;
    ntot++; if (rd_of(0) !== 8'h55) $display("FAIL abort_rd_next got %h want 55", rd_of(0)); else npass++;
    ntot++; if (rrdy_of(0) !== 1'b1) $display("FAIL abort_rrdy_next got %b want 1", rrdy_of(0)); else npass++;
    cs_high(0);
    rd_ack(0);
  endtask

  task automatic test_overrun();
    cs_low(0);
    xfer(0, 8'hAA, rx);
    xfer(0, 8'hBB, rx);
    cs_high(0);
`ifdef SPI_SLV_OVR_EN
    ntot++; if (rd_of(0) !== 8'hAA) $display("FAIL ovr_rd got %h want aa", rd_of(0)); else npass++;
    ntot++; if (ovr[0] !== 1'b1) $display("FAIL ovr_flag got %b want 1", ovr[0]); else npass++;
    rd_ack(0);
    ntot++; if (ovr[0] !== 1'b0) $display("FAIL ovr_clr got %b want 0", ovr[0]); else npass++;
`else
    ntot++; if (rd_of(0) !== 8'hBB) $display("FAIL ovr_rd got %h want bb", rd_of(0)); else npass++;
    ntot++; if (rrdy_of(0) !== 1'b1) $display("FAIL ovr_rrdy got %b want 1", rrdy_of(0)); else npass++;
    rd_ack(0);
`endif
    ntot++; if (rrdy_of(0) !== 1'b0) $display("FAIL ovr_rrdy_ack got %b want 0", rrdy_of(0)); else npass++;
  endtask

  task automatic test_rst_mid();
    wr_td(0, 8'hF0);
    cs_low(0);
    partial0();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    ntot++; if (b0.TRdy !== 1'b1) $display("FAIL rmid_trdy got %b want 1", b0.TRdy); else npass++;
    ntot++; if (b0.RRdy !== 1'b0) $display("FAIL rmid_rrdy got %b want 0", b0.RRdy); else npass++;
    ntot++; if (b0.RD !== 8'h00) $display("FAIL rmid_rd got %h want 00", b0.RD); else npass++;
    ntot++; if (miso[0] !== 1'b0) $display("FAIL rmid_miso got %b want 0", miso[0]); else npass++;
    ntot++; if (oe[0] !== 1'b0) $display("FAIL rmid_oe got %b want 0", oe[0]); else npass++;
    rst = 1'b0;
    sck[0] = 1'b0;
    repeat (10) @(negedge clk);
    ntot++; if (oe[0] !== 1'b0) $display("FAIL rmid_oe_hold got %b want 0", oe[0]); else npass++;
    cs_high(0);
    cs_low(0);
    ntot++; if (oe[0] !== 1'b1) $display("FAIL rmid_oe_fresh got %b want 1", oe[0]); else npass++;
    xfer(0, 8'h66, rx);
    ntot++; if (rx !== 8'hFF) $display("FAIL rmid_miso_def got %h want ff", rx); else npass++;
    ntot++; if (b0.RD !== 8'h66) $display("FAIL rmid_rd_new got %h want 66", b0.RD); else npass++;
    cs_high(0);
  endtask

  initial begin
    rst = 1'b1; ncs = 2'b11; sck = 2'b10; mosi = 1'b0;
    b0.TD = '0; b0.TD_WE = 1'b0; b0.RD_RE = 1'b0;
    b1.TD = '0; b1.TD_WE = 1'b0; b1.RD_RE = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_rst_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
